// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants and types for the fetch/decode slice.
// Rev 1.0
`default_nettype none

package riscv_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Opcodes consumed by the main decoder from instr_D[6:0]
  localparam logic [6:0] OPCODE_LW  = 7'b0000011;
  localparam logic [6:0] OPCODE_ADD = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } fd_reg_t;

  localparam fd_reg_t FD_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// if_id_register: F/D pipeline register with load, hold and bubble insertion.
// Rev 1.0
`default_nettype none

module if_id_register
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pc_plus4_D,
  output logic            valid_D
);

  fd_reg_t r_fd;

  // Bubble outranks stall so a flush is never lost behind a held stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fd <= FD_BUBBLE;
    end else if (bubble) begin
      r_fd <= FD_BUBBLE;
    end else if (!stall) begin
      r_fd <= '{instr: instr_in, pc: pc_in, pc_plus4: pc_plus4_in, valid: 1'b1};
    end
  end

  assign instr_D    = r_fd.instr;
  assign pc_D       = r_fd.pc;
  assign pc_plus4_D = r_fd.pc_plus4;
  assign valid_D    = r_fd.valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, redirect/stall handling and F/D register.
// Optional FETCH_PERF_CNT_EN adds fetch_count_D (count of valid F/D loads). Rev 1.0
`default_nettype none

module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            stall_D,
  input  logic            flush_D,
  input  logic            pc_src_E,
  input  logic [XLEN-1:0] pc_target_E,
  output logic [XLEN-1:0] imem_addr_F,
  input  logic [XLEN-1:0] imem_rdata_F,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pc_plus4_D,
  output logic            valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count_D
`endif
);

  logic [XLEN-1:0] pc_F;
  logic [XLEN-1:0] pc_plus4_F;
  logic            fd_bubble;

  assign pc_plus4_F  = pc_F + PC_INCR;
  assign imem_addr_F = pc_F;
  // A redirect also squashes the wrong-path word currently being fetched
  assign fd_bubble   = flush_D | pc_src_E;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_F <= RESET_PC;
    end else if (pc_src_E) begin
      pc_F <= pc_target_E & ALIGN_MASK;
    end else if (!stall_F) begin
      pc_F <= pc_plus4_F;
    end
  end

  if_id_register u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall_D),
    .bubble      (fd_bubble),
    .instr_in    (imem_rdata_F),
    .pc_in       (pc_F),
    .pc_plus4_in (pc_plus4_F),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .pc_plus4_D  (pc_plus4_D),
    .valid_D     (valid_D)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (!fd_bubble && !stall_D) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  assign fetch_count_D = fetch_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized + directed scoreboard bench for fetch_stage.
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall_F, stall_D, flush_D, pc_src_E;
  logic [31:0] pc_target_E;
  logic [31:0] imem_addr_F, imem_rdata_F, instr_D, pc_D, pc_plus4_D;
  logic        valid_D;
  logic [31:0] fetch_count_D;

  always #5 clk = ~clk;

  // Address-derived instruction memory so each word identifies where it came from
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata_F = mem_word(imem_addr_F);

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .pc_src_E     (pc_src_E),
    .pc_target_E  (pc_target_E),
    .imem_addr_F  (imem_addr_F),
    .imem_rdata_F (imem_rdata_F),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .pc_plus4_D   (pc_plus4_D),
    .valid_D      (valid_D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_D(fetch_count_D)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign fetch_count_D = '0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model state: architectural view of the fetch stage
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after every rising edge compare DUT against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("imem_addr_F", imem_addr_F, e.addr);
      check("instr_D", instr_D, e.instr);
      check("pc_D", pc_D, e.pc);
      check("pc_plus4_D", pc_plus4_D, e.pc4);
      check("valid_D", {31'd0, valid_D}, {31'd0, e.valid});
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count_D", fetch_count_D, e.cnt);
`endif
    end
  end

  // Drive one cycle of inputs, advance the model, queue the post-edge expectation
  task automatic cycle(input logic r, input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst_n = r; stall_F = sf; stall_D = sd; flush_D = fl; pc_src_E = src; pc_target_E = tgt;
    if (!r) begin
      m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
      m_pc = RST_PC;
    end else begin
      if (fl || src) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      end else if (!sd) begin
        m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
        m_cnt = m_cnt + 1;
      end
      if (src) m_pc = (tgt / 4) * 4;
      else if (!sf) m_pc = m_pc + 32'd4;
    end
    e = '{addr: m_pc, instr: m_instr, pc: m_pcd, pc4: m_pc4, valid: m_valid, cnt: m_cnt};
    expq.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 0; stall_F = 0; stall_D = 0; flush_D = 0; pc_src_E = 0; pc_target_E = 0;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;

    // Reset, then free-run from RESET_PC
    cycle(0, 0, 0, 0, 0, 32'h0);
    cycle(0, 1, 1, 0, 1, 32'h40);
    run(4);
    // Joint stall for two cycles, then resume
    cycle(1, 1, 1, 0, 0, 32'h0);
    cycle(1, 1, 1, 0, 0, 32'h0);
    run(2);
    // Redirect with stall_F in the same cycle (misaligned target)
    cycle(1, 1, 0, 0, 1, 32'h0000_0103);
    run(2);
    // Flush overriding stall_D
    cycle(1, 0, 1, 1, 0, 32'h0);
    // stall_F only: F/D keeps loading the held PC
    cycle(1, 1, 0, 0, 0, 32'h0);
    run(1);
    // Reset in the middle of a stall and a redirect
    cycle(0, 1, 1, 1, 1, 32'h0000_0800);
    run(2);
    // PC wrap across 2^32
    cycle(1, 0, 0, 0, 1, 32'hFFFF_FFF8);
    run(4);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom());
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual=%0d pending expected=0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall_F  input  1  hold PC this cycle.
REQ-005 stall_D  input  1  hold F/D pipeline register this cycle.
REQ-006 flush_D  input  1  replace F/D register contents with a bubble this cycle.
REQ-007 pc_src_E  input  1  redirect request from execute (taken branch/jump).
REQ-008 pc_target_E  input  32  redirect target address.
REQ-009 imem_addr_F  output  32  instruction memory address (combinational read memory).
REQ-010 imem_rdata_F  input  32  instruction word at imem_addr_F, same cycle.
REQ-011 instr_D  output  32  registered instruction to decode; bits [6:0] drive the main decoder opcode.
REQ-012 pc_D  output  32  registered PC of instr_D.
REQ-013 pc_plus4_D  output  32  registered pc_D + 4.
REQ-014 valid_D  output  1  instr_D is a real fetched instruction (0 = bubble).

Function
REQ-015 imem_addr_F SHALL equal the PC register pc_F combinationally.
REQ-016 PC next-state priority: rst_n low -> RESET_PC; else pc_src_E -> {pc_target_E[31:2],2'b00}; else stall_F -> hold; else pc_F + 4.
REQ-017 pc_F + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc_plus4_D SHALL wrap likewise.
REQ-018 Redirect SHALL take priority over stall_F when both are asserted in the same cycle.
REQ-019 F/D register priority: rst_n low -> reset values; else flush_D or pc_src_E -> bubble; else stall_D -> hold all four outputs; else load imem_rdata_F, pc_F, pc_F+4, valid_D=1.
REQ-020 Bubble: instr_D = 32'h0000_0013 (addi x0,x0,0), pc_D = 0, pc_plus4_D = 0, valid_D = 0.
REQ-021 Flush SHALL override stall_D when both are asserted.
REQ-022 Latency: word read at imem_addr_F in cycle n SHALL appear on instr_D in cycle n+1 when neither stalled nor flushed.
REQ-023 stall_F without stall_D SHALL still load the F/D register (pipeline control owns consistency; no internal coupling).
REQ-024 No combinational path from any input to instr_D, pc_D, pc_plus4_D or valid_D.

Reset
REQ-025 Synchronous active-low: on a rising edge with rst_n=0, pc_F = RESET_PC and F/D register = bubble values of REQ-020.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL win over all other inputs.
REQ-027 First cycle after rst_n rises: imem_addr_F = RESET_PC, valid_D = 0; next cycle valid_D = 1 with pc_D = RESET_PC.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN: when defined, adds output fetch_count_D (32-bit) counting F/D loads with valid_D=1 (REQ-019 last branch).
REQ-029 With FETCH_PERF_CNT_EN, fetch_count_D resets to 0, does not count during stall/flush/bubble, and wraps at 2^32.
REQ-030 Without FETCH_PERF_CNT_EN, the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, PC_INCR=4 and the opcode constants (lw 7'b0000011, add 7'b0110011) used by the decoder.
REQ-032 One sub-module if_id_register SHALL implement the F/D register (load/hold/bubble); PC logic stays in fetch_stage.

Verification
REQ-033 Reset then 4 free-run cycles, imem returns addr-based words -> imem_addr_F 0,4,8,12; pc_D 0,4,8 one cycle later, valid_D 0 then 1.
REQ-034 stall_F=1 and stall_D=1 for 2 cycles at pc_F=8 -> imem_addr_F holds 8, instr_D/pc_D hold pc 4 contents, then resume at 12.
REQ-035 pc_src_E=1, pc_target_E=32'h0000_0103, stall_F=1 same cycle -> next imem_addr_F=32'h0000_0100, instr_D=32'h0000_0013, valid_D=0.
REQ-036 flush_D=1 with stall_D=1 -> next instr_D=NOP, valid_D=0, pc_D=0.
REQ-037 RESET_PC=32'hFFFF_FFF8, free-run -> imem_addr_F FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_D for pc FFFF_FFFC = 0.
REQ-038 FETCH_PERF_CNT_EN defined, 5 valid loads, 2 stalls, 1 flush -> fetch_count_D = 5; rst_n low mid-run -> 0 next edge.
